// File: rtl/corefifo_pkg.sv
// Shared definitions for the single-clock FIFO controller.
//   clog2        : constant-time address width helper
//   fifo_flags_t : registered status flag bundle {full, empty, afull, aempty}
//   DEF_WIDTH / DEF_DEPTH : default data width and entry count
package corefifo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 128;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } fifo_flags_t;

endpackage

// File: rtl/corefifo_rd_pipe.sv
// Read-data return path: delays the pop-accept strobe to DVLD and optionally
// registers the RAM read data once more before it reaches Q.
//   clk, rst   : clock, synchronous active-high reset
//   rd_acc     : pop accepted this cycle (RAM read issued)
//   ram_rdata  : RAM read data, valid one cycle after rd_acc
//   q, dvld    : pop data and its one-cycle valid strobe
module corefifo_rd_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_acc,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [WIDTH-1:0] q,
    output logic             dvld
);

    // One stage for the RAM read latency, plus one for the optional Q register.
    localparam int STAGES = PIPE + 1;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:1] vld_q;

    assign vld_pipe = {vld_q, rd_acc};
    assign dvld     = vld_pipe[STAGES];

    // Reset clears the delay line so a pop in flight never produces DVLD.
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_pipe[STAGES-1:0];
    end

    generate
        if (PIPE == 0) begin : g_direct
            assign q = ram_rdata;
        end else begin : g_reg
            logic [WIDTH-1:0] q_r;
            // Capture only when the RAM data belongs to a pop, so Q holds between pops.
            always_ff @(posedge clk) begin
                if (rst)              q_r <= '0;
                else if (vld_pipe[1]) q_r <= ram_rdata;
            end
            assign q = q_r;
        end
    endgenerate

endmodule

// File: rtl/corefifo_sync_ctrl.sv
// Single-clock FIFO controller for an LSRAM storage wrapper. Owns pointers,
// occupancy and status flags, gates pushes and pops, and returns read data.
//   CLOCK, RESET          : clock, synchronous active-high reset
//   WE, DATA              : push request and data
//   RE, Q, DVLD           : pop request, pop data, pop data valid strobe
//   FULL/EMPTY/AFULL/AEMPTY, WRCNT : registered status and occupancy
//   OVERFLOW/UNDERFLOW    : one-cycle pulse after a rejected push/pop
//   RAM_*                 : write/read ports to the storage wrapper
module corefifo_sync_ctrl
    import corefifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = clog2(DEPTH),
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8,
    parameter int PIPE      = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             WE,
    input  logic [WIDTH-1:0] DATA,
    input  logic             RE,
    output logic [WIDTH-1:0] Q,
    output logic             DVLD,
    output logic             FULL,
    output logic             EMPTY,
    output logic             AFULL,
    output logic             AEMPTY,
    output logic [AW:0]      WRCNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW,
    output logic [WIDTH-1:0] RAM_WDATA,
    output logic [AW-1:0]    RAM_WADDR,
    output logic             RAM_WEN,
    output logic [AW-1:0]    RAM_RADDR,
    output logic             RAM_REN,
    input  logic [WIDTH-1:0] RAM_RDATA
);

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, next_count;
    fifo_flags_t   flags_q;
    logic          wr_acc, rd_acc;
    logic          ovf_q, udf_q;

    // Acceptance uses only registered flags; RESET blocks any RAM access.
    assign wr_acc = WE & ~flags_q.full  & ~RESET;
    assign rd_acc = RE & ~flags_q.empty & ~RESET;

    always_comb begin
        next_count = count;
        if (wr_acc && !rd_acc)      next_count = count + 1'b1;
        else if (rd_acc && !wr_acc) next_count = count - 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            flags_q <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            count <= next_count;
            // Flags come from next_count so they are exact the cycle after the update.
            flags_q.full   <= (next_count == DEPTH_C);
            flags_q.empty  <= (next_count == '0);
            flags_q.afull  <= (next_count >= AFULL_C);
            flags_q.aempty <= (next_count <= AEMPTY_C);
            ovf_q <= WE & flags_q.full;
            udf_q <= RE & flags_q.empty;
        end
    end

    assign FULL      = flags_q.full;
    assign EMPTY     = flags_q.empty;
    assign AFULL     = flags_q.afull;
    assign AEMPTY    = flags_q.aempty;
    assign WRCNT     = count;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

    assign RAM_WDATA = DATA;
    assign RAM_WADDR = wptr;
    assign RAM_WEN   = wr_acc;
    assign RAM_RADDR = rptr;
    assign RAM_REN   = rd_acc;

    corefifo_rd_pipe #(
        .WIDTH (WIDTH),
        .PIPE  (PIPE)
    ) u_rd_pipe (
        .clk       (CLOCK),
        .rst       (RESET),
        .rd_acc    (rd_acc),
        .ram_rdata (RAM_RDATA),
        .q         (Q),
        .dvld      (DVLD)
    );

endmodule
